// File: rtl/pc_jump_pkg.sv
// Shared definitions for the PC jump unit: next-PC mode encodings and PC increment.
package pc_jump_pkg;

  typedef enum logic [2:0] {
    MODE_SEQ    = 3'd0,
    MODE_BRANCH = 3'd1,
    MODE_JUMP   = 3'd2,
    MODE_JAL    = 3'd3,
    MODE_JR     = 3'd4,
    MODE_RET    = 3'd5
  } mode_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_jump_unit_ras.sv
// Circular return-address stack for pc_jump_unit; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // sp_q points at the next free slot; wrapping it makes overwrite-on-full implicit.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d = sp_q + AW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop && (cnt_q != '0)) begin
      sp_d  = sp_q - AW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (push) mem_q[sp_q] <= push_data;
    end
  end

  assign top   = mem_q[sp_q - AW'(1)];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/pc_jump_unit.sv
// Program-counter next-address unit with optional return-address stack.
// Define PC_JUMP_RAS_EN to build the stack; otherwise JAL acts as JUMP and RET as JR.
module pc_jump_unit
  import pc_jump_pkg::*;
#(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          IMM_W     = 26,
  parameter int unsigned          RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]      RESET_PC  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pc_write,
  input  logic [2:0]       mode,
  input  logic [IMM_W-1:0] immediate,
  input  logic [15:0]      br_offset,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  link_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign_err
);

  localparam logic [PC_W-1:0] JMP_KEEP = ~({PC_W{1'b1}} >> (PC_W - IMM_W - 2));

  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] seq_pc, br_ext, jmp_pc, jr_pc;
  logic [17:0]     br_sh;
  logic [PC_W-1:0] ras_top;
  logic            ras_hit;
  mode_e           mode_sel;

  assign mode_sel  = mode_e'(mode);
  assign seq_pc    = pc_q + PC_W'(PC_INC);
  assign br_sh     = {br_offset, 2'b00};
  assign br_ext    = PC_W'($signed(br_sh));
  assign jmp_pc    = (pc_q & JMP_KEEP) | (PC_W'(immediate) << 2);
  assign jr_pc     = {reg_target[PC_W-1:2], 2'b00};

`ifdef PC_JUMP_RAS_EN
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  logic          ras_push, ras_pop;
  logic [CW-1:0] ras_count;

  assign ras_push = pc_write && (mode_sel == MODE_JAL);
  assign ras_pop  = pc_write && (mode_sel == MODE_RET);
  assign ras_hit  = (ras_count != '0);

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  // An empty stack makes RET fall through to the JR path, misalign check included.
  always_comb begin
    pc_d  = pc_q;
    err_d = 1'b0;
    if (pc_write) begin
      case (mode_sel)
        MODE_BRANCH: pc_d = seq_pc + br_ext;
        MODE_JUMP,
        MODE_JAL:    pc_d = jmp_pc;
        MODE_JR: begin
          pc_d  = jr_pc;
          err_d = (reg_target[1:0] != 2'b00);
        end
        MODE_RET: begin
          if (ras_hit) begin
            pc_d = ras_top;
          end else begin
            pc_d  = jr_pc;
            err_d = (reg_target[1:0] != 2'b00);
          end
        end
        default:     pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc           = pc_q;
  assign link_addr    = seq_pc;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit: directed scenarios then random traffic against a queue-based model.
module tb_pc_jump_unit;

  localparam int unsigned DEPTH = 4;

`ifdef PC_JUMP_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_write;
  logic [2:0]  mode;
  logic [25:0] immediate;
  logic [15:0] br_offset;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign_err;

  int n_checks = 0;
  int n_err    = 0;

  bit [31:0] m_pc;
  bit        m_err;
  bit [31:0] m_stk[$];

  pc_jump_unit #(
    .PC_W      (32),
    .IMM_W     (26),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pc_write     (pc_write),
    .mode         (mode),
    .immediate    (immediate),
    .br_offset    (br_offset),
    .reg_target   (reg_target),
    .pc           (pc),
    .link_addr    (link_addr),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .misalign_err (misalign_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: plain arithmetic on the PC plus a bounded queue as the stack.
  task automatic model(input bit r, input bit pw, input bit [2:0] md, input bit [25:0] im,
                       input bit [15:0] off, input bit [31:0] tg);
    bit [31:0] nxt;
    bit        e;
    if (r) begin
      m_pc  = 32'h0;
      m_err = 1'b0;
      m_stk.delete();
      return;
    end
    if (!pw) begin
      m_err = 1'b0;
      return;
    end
    e = 1'b0;
    case (md)
      3'd1: nxt = m_pc + 32'd4 + 32'(int'($signed(off)) * 4);
      3'd2: nxt = (m_pc - (m_pc % 32'h1000_0000)) + 32'(im) * 4;
      3'd3: begin
        nxt = (m_pc - (m_pc % 32'h1000_0000)) + 32'(im) * 4;
        if (RAS_ON) begin
          m_stk.push_back(m_pc + 32'd4);
          if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
        end
      end
      3'd4: begin
        nxt = tg - (tg % 4);
        e   = (tg % 4) != 0;
      end
      3'd5: begin
        if (RAS_ON && m_stk.size() > 0) begin
          nxt = m_stk.pop_back();
        end else begin
          nxt = tg - (tg % 4);
          e   = (tg % 4) != 0;
        end
      end
      default: nxt = m_pc + 32'd4;
    endcase
    m_pc  = nxt;
    m_err = e;
  endtask

  task automatic step(input string tag, input bit r, input bit pw, input bit [2:0] md,
                      input bit [25:0] im, input bit [15:0] off, input bit [31:0] tg);
    RST = r; pc_write = pw; mode = md; immediate = im; br_offset = off; reg_target = tg;
    model(r, pw, md, im, off, tg);
    @(posedge CLK);
    #1;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".link"}, link_addr, m_pc + 32'd4);
    chk({tag, ".empty"}, 32'(ras_empty), RAS_ON ? 32'(m_stk.size() == 0) : 32'd1);
    chk({tag, ".full"}, 32'(ras_full), RAS_ON ? 32'(m_stk.size() == DEPTH) : 32'd0);
    chk({tag, ".err"}, 32'(misalign_err), 32'(m_err));
  endtask

  initial begin
    RST = 1'b1; pc_write = 1'b0; mode = '0; immediate = '0; br_offset = '0; reg_target = '0;
    #1;

    step("reset", 1, 0, 0, 0, 0, 0);
    step("seq0", 0, 1, 0, 0, 0, 0);
    step("seq1", 0, 1, 0, 0, 0, 0);
    step("seq2", 0, 1, 0, 0, 0, 0);
    chk("seq_const", pc, 32'h0000_000C);

    step("jr40", 0, 1, 4, 0, 0, 32'h40);
    step("br_neg", 0, 1, 1, 0, 16'hFFFE, 0);
    chk("br_neg_const", pc, 32'h3C);
    step("jr40b", 0, 1, 4, 0, 0, 32'h40);
    step("br_pos", 0, 1, 1, 0, 16'h0003, 0);
    chk("br_pos_const", pc, 32'h50);

    step("jr_hi", 0, 1, 4, 0, 0, 32'h9000_0010);
    step("jal", 0, 1, 3, 26'h0000100, 0, 0);
    chk("jal_const", pc, 32'h9000_0400);
    step("ret", 0, 1, 5, 0, 0, 32'h0000_2000);

    step("wrap_jr", 0, 1, 4, 0, 0, 32'hFFFF_FFFC);
    step("wrap_seq", 0, 1, 0, 0, 0, 0);
    chk("wrap_const", pc, 32'h0);

    for (int i = 0; i < 5; i++) step("jal5", 0, 1, 3, 26'(32'h100 * (i + 1)), 0, 0);
    for (int i = 0; i < 5; i++) step("ret5", 0, 1, 5, 0, 0, 32'h0000_3000);

    step("jr_mis", 0, 1, 4, 0, 0, 32'h0000_1003);
    chk("jr_mis_const", pc, 32'h0000_1000);
    chk("jr_mis_pulse", 32'(misalign_err), 32'd1);
    step("hold", 0, 0, 4, 26'h3FF_FFFF, 16'h1234, 32'h0000_5557);
    chk("hold_const", pc, 32'h0000_1000);

    step("rsv6", 0, 1, 6, 0, 0, 32'h7);
    step("rsv7", 0, 1, 7, 0, 0, 32'h7);

    step("jal_a", 0, 1, 3, 26'h40, 0, 0);
    step("jal_b", 0, 1, 3, 26'h80, 0, 0);
    step("rst_jal", 1, 1, 3, 26'h44, 0, 0);
    chk("rst_jal_pc", pc, 32'h0);
    chk("rst_jal_empty", 32'(ras_empty), 32'd1);
    step("ret_after_rst", 0, 1, 5, 0, 0, 32'h0000_5002);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 26'($urandom), 16'($urandom), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_jump_unit.md
PC_JUMP_UNIT -- requirements
Module: pc_jump_unit

Interface
REQ-001 Parameter PC_W, default 32, SHALL set the program-counter width in bits.
REQ-002 Parameter IMM_W, default 26, SHALL set the jump-immediate width; PC_W >= IMM_W+2 is required.
REQ-003 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack depth (power of two, >= 2).
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 Port list SHALL be, in order:
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous active-high reset.
- pc_write  in  1  PC update enable.
- mode  in  3  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JAL, 4 JR, 5 RET, 6-7 reserved.
- immediate  in  IMM_W  jump target field.
- br_offset  in  16  signed branch word offset.
- reg_target  in  PC_W  register-sourced target.
- pc  out  PC_W  current PC, registered.
- link_addr  out  PC_W  pc+4, combinational from pc.
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- misalign_err  out  1  one-cycle pulse on misaligned register target.

Function
REQ-006 With pc_write low, pc, stack contents, stack count and misalign_err SHALL be held or cleared as follows: pc and stack held, misalign_err 0; mode and data inputs ignored.
REQ-007 With pc_write high, pc SHALL load the next PC selected by mode on the same edge (1-cycle latency).
REQ-008 Arithmetic SHALL be modulo 2^PC_W; pc+4 from all-ones-minus-3 wraps to 0.
REQ-009 SEQ: next = pc+4.
REQ-010 BRANCH: next = pc+4 + (sign-extended br_offset << 2), truncated to PC_W.
REQ-011 JUMP: next = {pc[PC_W-1:IMM_W+2], immediate, 2'b00}.
REQ-012 JAL: next as JUMP; link_addr (pc+4) pushed onto the stack on the same edge.
REQ-013 JR: next = {reg_target[PC_W-1:2], 2'b00}.
REQ-014 RET with stack non-empty: next = top entry, entry popped on the same edge.
REQ-015 RET with stack empty: behave as JR; no pop; count stays 0.
REQ-016 Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_full stays 1.
REQ-017 misalign_err SHALL be 1 for exactly the cycle after an edge where JR, or RET-fallback, was taken with reg_target[1:0] != 0.
REQ-018 Reserved modes 6-7 SHALL behave as SEQ.
REQ-019 ras_empty/ras_full SHALL be registered-state derived, valid in the cycle after each push/pop.

Reset
REQ-020 On RST high at a rising edge: pc = RESET_PC, stack count 0 (ras_empty 1, ras_full 0), misalign_err 0; RST overrides pc_write.
REQ-021 Reset asserted mid-sequence SHALL discard all stack entries; no partial push/pop survives.

Configuration
REQ-022 Macro PC_JUMP_RAS_EN defined: stack built as specified.
REQ-023 Macro PC_JUMP_RAS_EN undefined: no stack storage; JAL behaves as JUMP, RET behaves as JR (including misalign check); ras_empty tied 1, ras_full tied 0.

Structure
REQ-024 Package pc_jump_pkg SHALL hold the mode encodings (typedef) and the constant 4 for the PC increment.
REQ-025 Stack SHALL be a sub-module pc_ras (push, pop, top, count, empty, full), instantiated only under PC_JUMP_RAS_EN.

Verification
REQ-026 Reset, then SEQ x3 with pc_write=1 -> pc 0x0, 0x4, 0x8, 0xC.
REQ-027 pc=0x40, BRANCH br_offset=0xFFFE -> pc 0x3C; br_offset=0x0003 from 0x40 -> 0x50.
REQ-028 pc=0x90000010, JAL immediate=0x0000100 -> pc 0x90000400, stack top 0x90000014; then RET -> pc 0x90000014, ras_empty 1.
REQ-029 Five JALs with RAS_DEPTH=4 -> ras_full 1 after fourth; four RETs return links 5,4,3,2 in order; fifth RET uses reg_target.
REQ-030 JR reg_target=0x00001003 -> pc 0x00001000, misalign_err pulses one cycle; pc_write=0 cycle holds pc and clears err.
REQ-031 RST during JAL cycle and at pc_write=1 -> pc=RESET_PC, ras_empty 1; repeat with PC_JUMP_RAS_EN undefined: RET equals JR.
